// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 link constants, FSM states and ns-to-cycle conversion
package ws2812_pkg;
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_e;
  localparam int BITS_PER_WORD = 24;
  localparam int T0H_NS = 400;
  localparam int T1H_NS = 800;
  localparam int PERIOD_NS = 1250;
  localparam int RESET_NOM_NS = 50_000;
  function automatic int ns2cyc(input int f_clk, input int ns);
    return f_clk / 1_000_000 * ns / 1000;
  endfunction
endpackage

// File: rtl/ws2812_pulse_timer.sv
// ws2812_pulse_timer: din synchroniser, registered edge detect, high/low width counters
// clk_i, reset_n_i : clock, async active-low reset
// din_i            : raw serial line
// s2_o             : synchronised line level
// rise_o, fall_o   : one-cycle edge pulses
// hc_o             : width of current/last high pulse in cycles
// hc_over_o        : high pulse is about to exceed MAX_C
// lc_done_o        : line has been low for RESET_C cycles
module ws2812_pulse_timer #(
  parameter int MAX_C = 100,
  parameter int RESET_C = 2500,
  parameter int HW = 7,
  parameter int LW = 12
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          din_i,
  output logic          s2_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic [HW-1:0] hc_o,
  output logic          hc_over_o,
  output logic          lc_done_o
);
  logic s1_q, s2_q, s3_q, rise_q, fall_q;
  logic [HW-1:0] hc_q;
  logic [LW-1:0] lc_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      hc_q <= '0;
      lc_q <= '0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
      // s3 is the level aligned with the registered edges, so both counters measure exact widths
      hc_q <= rise_q ? HW'(1) : (s3_q && hc_q != HW'(MAX_C + 1)) ? hc_q + 1'b1 : hc_q;
      lc_q <= fall_q ? LW'(1) : (!s3_q && lc_q != LW'(RESET_C)) ? lc_q + 1'b1 : lc_q;
    end
  end
  assign s2_o = s2_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign hc_o = hc_q;
  assign hc_over_o = s3_q & ~rise_q & (hc_q == HW'(MAX_C));
  assign lc_done_o = ~s3_q & ~fall_q & (lc_q >= LW'(RESET_C - 1));
endmodule

// File: rtl/ws2812_receiver.sv
// ws2812_receiver: WS2812 NRZ decoder capturing 24-bit words and forwarding the rest of a frame
// clk_i, reset_n_i : clock, async active-low reset
// din_i            : serial LED data (asynchronous)
// data_out_o       : last captured {G,R,B} word
// data_valid_o     : pulse when data_out_o updates
// frame_end_o      : pulse on reset-length low gap after activity
// bit_error_o      : pulse on pulse-width violation
// dout_o           : forwarded serial stream
// word_count_o     : words decoded in current frame (saturating)
module ws2812_receiver
  import ws2812_pkg::*;
#(
  parameter int F_CLK = 50_000_000,
  parameter int THRESH_NS = 600,
  parameter int MIN_HIGH_NS = 150,
  parameter int MAX_HIGH_NS = 2000,
  parameter int RESET_NS = 50_000,
  parameter bit PASS_THROUGH = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        din_i,
  output logic [23:0] data_out_o,
  output logic        data_valid_o,
  output logic        frame_end_o,
  output logic        bit_error_o,
  output logic        dout_o,
  output logic [15:0] word_count_o
);
  localparam int THRESH_C = ns2cyc(F_CLK, THRESH_NS);
  localparam int MIN_C = ns2cyc(F_CLK, MIN_HIGH_NS);
  localparam int MAX_C = ns2cyc(F_CLK, MAX_HIGH_NS);
  localparam int RESET_C = ns2cyc(F_CLK, RESET_NS);
  localparam int HW = $clog2(MAX_C + 2);
  localparam int LW = $clog2(RESET_C + 1);
  localparam int BW = $clog2(BITS_PER_WORD);
  logic s2, rise, fall, hc_over, lc_done, b;
  logic [HW-1:0] hc;
  state_e state_q, state_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [23:0] shreg_q, shreg_d, data_q, data_d;
  logic dv_q, dv_d, fe_q, fe_d, err_q, err_d, fwd_q, fwd_d, dout_q;
  logic [15:0] wc_q, wc_d;
  ws2812_pulse_timer #(.MAX_C(MAX_C), .RESET_C(RESET_C), .HW(HW), .LW(LW)) u_tmr (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .din_i(din_i),
    .s2_o(s2),
    .rise_o(rise),
    .fall_o(fall),
    .hc_o(hc),
    .hc_over_o(hc_over),
    .lc_done_o(lc_done)
  );
  assign b = hc >= HW'(THRESH_C);
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d = shreg_q;
    data_d = data_q;
    dv_d = 1'b0;
    fe_d = 1'b0;
    err_d = 1'b0;
    wc_d = wc_q;
    fwd_d = fwd_q;
    case (state_q)
      SYNC: state_d = lc_done ? IDLE : SYNC;
      IDLE: if (rise) begin
        wc_d = '0;
        bitcnt_d = '0;
        state_d = HIGH;
      end
      HIGH: if (hc_over || (fall && hc < HW'(MIN_C))) begin
        err_d = 1'b1;
        fwd_d = 1'b0;
        bitcnt_d = '0;
        state_d = SYNC;
      end else if (fall) begin
        shreg_d = {shreg_q[22:0], b};
        state_d = LOW;
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == BW'(BITS_PER_WORD - 1)) begin
          bitcnt_d = '0;
          // once forwarding, later words are width-checked but not captured
          if (!(PASS_THROUGH && fwd_q)) begin
            data_d = {shreg_q[22:0], b};
            dv_d = 1'b1;
            wc_d = wc_q + {15'd0, ~&wc_q};
            fwd_d = PASS_THROUGH;
          end
        end
      end
      LOW: if (rise) state_d = HIGH;
      else if (lc_done) begin
        fe_d = 1'b1;
        fwd_d = 1'b0;
        bitcnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= SYNC;
      bitcnt_q <= '0;
      shreg_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      err_q <= 1'b0;
      wc_q <= '0;
      fwd_q <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q <= shreg_d;
      data_q <= data_d;
      dv_q <= dv_d;
      fe_q <= fe_d;
      err_q <= err_d;
      wc_q <= wc_d;
      fwd_q <= fwd_d;
      dout_q <= s2 & fwd_q;
    end
  end
  assign data_out_o = data_q;
  assign data_valid_o = dv_q;
  assign frame_end_o = fe_q;
  assign bit_error_o = err_q;
  assign dout_o = dout_q;
  assign word_count_o = wc_q;
endmodule

// File: tb/tb_ws2812_receiver.sv
// tb_ws2812_receiver: directed self-checking bench for ws2812_receiver in both modes
module tb_ws2812_receiver;
  import ws2812_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, din = 1'b0;
  logic [23:0] do0, do1;
  logic dv0, dv1, fe0, fe1, be0, be1, dout0, dout1, dprev = 1'b0;
  logic [15:0] wc0, wc1;
  logic [23:0] log1 [64];
  int total = 0, bad = 0;
  int nv0 = 0, nv1 = 0, nf0 = 0, ne0 = 0, ne1 = 0, ndr = 0, ndh = 0, nd1h = 0, hc_err = 0;
  int s_v0, s_v1, s_f0, s_e0, s_e1, s_dr, s_dh;
  always #10 clk = ~clk;
  ws2812_receiver u0 (
    .clk_i(clk), .reset_n_i(reset_n), .din_i(din), .data_out_o(do0), .data_valid_o(dv0),
    .frame_end_o(fe0), .bit_error_o(be0), .dout_o(dout0), .word_count_o(wc0)
  );
  ws2812_receiver #(.PASS_THROUGH(1'b0)) u1 (
    .clk_i(clk), .reset_n_i(reset_n), .din_i(din), .data_out_o(do1), .data_valid_o(dv1),
    .frame_end_o(fe1), .bit_error_o(be1), .dout_o(dout1), .word_count_o(wc1)
  );
  always @(negedge clk) begin
    if (dv0) nv0++;
    if (dv1) begin
      log1[nv1 % 64] = do1;
      nv1++;
    end
    if (fe0) nf0++;
    if (be0) begin
      ne0++;
      hc_err = int'(u0.u_tmr.hc_q);
    end
    if (be1) ne1++;
    if (dout0 && !dprev) ndr++;
    if (dout0) ndh++;
    if (dout1) nd1h++;
    dprev = dout0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    s_v0 = nv0; s_v1 = nv1; s_f0 = nf0; s_e0 = ne0; s_e1 = ne1; s_dr = ndr; s_dh = ndh;
  endtask
  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    #hi;
    din = 1'b0;
    #lo;
  endtask
  task automatic send_top(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) if (w[i]) pulse(800, 440); else pulse(400, 840);
  endtask
  task automatic send_word(input logic [23:0] w);
    send_top(w, 24);
  endtask
  initial begin
    #50;
    chk("rst_data", do0, 0);
    chk("rst_valid", dv0, 0);
    chk("rst_fe", fe0, 0);
    chk("rst_err", be0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_wc", wc0, 0);
    chk("rst_state", 32'(u0.state_q), 32'(SYNC));
    #50 reset_n = 1'b1;
    #52000;
    snap();
    send_word(24'hA5C3F0);
    #55000;
    chk("t1_nvalid", nv0 - s_v0, 1);
    chk("t1_data", do0, 24'hA5C3F0);
    chk("t1_fe", nf0 - s_f0, 1);
    chk("t1_wc", wc0, 1);
    chk("t1_err", ne0 - s_e0, 0);
    chk("t1_pt0_data", do1, 24'hA5C3F0);
    snap();
    send_word(24'h000001);
    send_word(24'h123456);
    send_word(24'hFFFFFF);
    #55000;
    chk("t2_data", do0, 24'h000001);
    chk("t2_nvalid", nv0 - s_v0, 1);
    chk("t2_wc", wc0, 1);
    chk("t2_dout_rises", ndr - s_dr, 48);
    chk("t2_dout_high", ndh - s_dh, 1620);
    chk("t2_dout_end", dout0, 0);
    chk("t2_pt0_nvalid", nv1 - s_v1, 3);
    chk("t2_pt0_data", do1, 24'hFFFFFF);
    chk("t2_pt0_wc", wc1, 3);
    chk("t2_pt0_dout", nd1h, 0);
    snap();
    for (int w = 0; w < 5; w++) send_word(24'(w));
    #55000;
    chk("t3_nvalid", nv1 - s_v1, 5);
    for (int k = 0; k < 5; k++) chk("t3_word", log1[(s_v1 + k) % 64], 32'(k));
    chk("t3_wc", wc1, 5);
    chk("t3_pt1_nvalid", nv0 - s_v0, 1);
    chk("t3_pt1_data", do0, 0);
    snap();
    pulse(2000, 440);
    pulse(140, 840);
    pulse(600, 440);
    pulse(580, 840);
    send_top({20'h55555, 4'h0}, 20);
    #55000;
    chk("bnd_data", do1, 24'hA55555);
    chk("bnd_err", ne1 - s_e1, 0);
    chk("bnd_pt1_data", do0, 24'hA55555);
    snap();
    send_top(24'h00FF00, 5);
    pulse(100, 840);
    send_top(24'hFFFFFF, 18);
    #10000;
    send_word(24'h777777);
    #55000;
    chk("t4_glitch_err", ne0 - s_e0, 1);
    chk("t4_glitch_err_pt0", ne1 - s_e1, 1);
    chk("t4_glitch_nvalid", nv0 - s_v0, 0);
    chk("t4_glitch_pt0_nvalid", nv1 - s_v1, 0);
    chk("t4_glitch_fe", nf0 - s_f0, 0);
    snap();
    send_top(24'h800000, 3);
    din = 1'b1;
    #3000;
    din = 1'b0;
    #55000;
    chk("t4_stuck_err", ne0 - s_e0, 1);
    chk("t4_stuck_hc", hc_err, 101);
    chk("t4_stuck_nvalid", nv0 - s_v0, 0);
    snap();
    send_word(24'h5A5A5A);
    #55000;
    chk("t4_recover_n", nv0 - s_v0, 1);
    chk("t4_recover_data", do0, 24'h5A5A5A);
    chk("t4_recover_err", ne0 - s_e0, 0);
    reset_n = 1'b0;
    #100;
    snap();
    send_top(24'hF0F0F0, 4);
    reset_n = 1'b1;
    send_top(24'hF0F0F0, 20);
    send_word(24'h333333);
    send_word(24'hCCCCCC);
    #55000;
    chk("t5_nvalid", nv0 - s_v0, 0);
    chk("t5_pt0_nvalid", nv1 - s_v1, 0);
    chk("t5_err", ne0 - s_e0, 0);
    chk("t5_fe", nf0 - s_f0, 0);
    snap();
    send_word(24'h0F0F0F);
    #55000;
    chk("t5_next_n", nv0 - s_v0, 1);
    chk("t5_next_data", do0, 24'h0F0F0F);
    chk("t5_next_fe", nf0 - s_f0, 1);
    chk("t5_next_wc", wc0, 1);
    send_top(24'hABCDEF, 12);
    din = 1'b1;
    #200;
    reset_n = 1'b0;
    #1;
    chk("t6_data", do0, 0);
    chk("t6_wc", wc0, 0);
    chk("t6_dout", dout0, 0);
    chk("t6_valid", dv0, 0);
    chk("t6_err", be0, 0);
    chk("t6_fe", fe0, 0);
    chk("t6_state", 32'(u0.state_q), 32'(SYNC));
    chk("t6_pt0_data", do1, 0);
    #19;
    din = 1'b0;
    #1000;
    reset_n = 1'b1;
    #200;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
